// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM controller: access sizes,
// FSM states, owners and the default RAM address width.
package mem_ctrl_pkg;

   localparam int RAM_ADDR_W_DEF = 17;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   // Byte counts are held as "index of the last byte" (N-1).
   localparam logic [1:0] LAST_BYTE = 2'd0;
   localparam logic [1:0] LAST_HALF = 2'd1;
   localparam logic [1:0] LAST_WORD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_ME = 1'b1
   } owner_t;

   function automatic logic [1:0] size_to_last(input logic [1:0] size);
      case (size)
         MEM_SIZE_BYTE: return LAST_BYTE;
         MEM_SIZE_HALF: return LAST_HALF;
         MEM_SIZE_WORD: return LAST_WORD;
         default:       return LAST_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_asm.sv
// Byte-lane word register: cleared for reads, loaded whole for writes,
// filled one lane at a time from RAM and read back one byte at a time.
module mem_byte_asm (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        ld_word,
   input  logic [31:0] word_in,
   input  logic        ld_lane,
   input  logic [1:0]  lane,
   input  logic [7:0]  byte_in,
   input  logic [1:0]  sel,
   output logic [31:0] word_out,
   output logic [7:0]  byte_out
);

   logic [31:0] word_q;

   // A new grant (clr/ld_word) wins over a late lane capture from an aborted read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
      end else if (clr) begin
         word_q <= '0;
      end else if (ld_word) begin
         word_q <= word_in;
      end else if (ld_lane) begin
         word_q[{lane, 3'b000} +: 8] <= byte_in;
      end
   end

   assign word_out = word_q;
   assign byte_out = word_q[{sel, 3'b000} +: 8];

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide synchronous RAM between instruction fetch and
// the ME stage, sequencing 1/2/4-byte little-endian accesses byte by byte.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W_DEF,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   input  logic              if_cancel_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_done_o,
   output logic              if_stall_req_o,
   input  logic              me_req_i,
   input  logic              me_we_i,
   input  logic [1:0]        me_size_i,
   input  logic [31:0]       me_addr_i,
   input  logic [DATA_W-1:0] me_wdata_i,
   output logic [DATA_W-1:0] me_rdata_o,
   output logic              me_done_o,
   output logic              me_stall_req_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [7:0]        ram_dout_o,
   output logic              ram_we_o,
   input  logic [7:0]        ram_din_i,
   output logic [1:0]        dbg_state_o
);

   // Handshake: a requester holds x_req_i (inputs sampled only at grant)
   // and sees x_stall_req_o until the one-cycle x_done_o; it advances on
   // the edge that ends the done cycle.

   state_t            state_q, state_d;
   owner_t            owner_q;
   logic              we_q;
   logic [1:0]        cnt_q;
   logic [1:0]        last_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cap_en_q;
   logic [1:0]        cap_lane_q;
   logic [31:0]       if_data_q;
   logic [31:0]       me_rdata_q;
   logic              grant_me, grant_if;
   logic              if_abort;
   logic [31:0]       asm_word;
   logic [7:0]        asm_byte;
   logic              unused_addr;

   assign unused_addr = ^{if_addr_i[31:ADDR_W], me_addr_i[31:ADDR_W]};
   assign if_abort    = (owner_q == OWN_IF) && if_cancel_i;

   always_comb begin
      state_d  = state_q;
      grant_me = 1'b0;
      grant_if = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (me_req_i) begin
               grant_me = 1'b1;
               state_d  = ST_ISSUE;
            end else if (if_req_i && !if_cancel_i) begin
               grant_if = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (if_abort)                state_d = ST_IDLE;
            else if (cnt_q == last_q)    state_d = we_q ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: state_d = if_abort ? ST_IDLE : ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         we_q       <= 1'b0;
         cnt_q      <= 2'd0;
         last_q     <= 2'd0;
         addr_q     <= '0;
         cap_en_q   <= 1'b0;
         cap_lane_q <= 2'd0;
         if_data_q  <= '0;
         me_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         // The byte addressed in this cycle arrives on ram_din_i next cycle.
         cap_en_q   <= (state_q == ST_ISSUE) && !we_q;
         cap_lane_q <= cnt_q;
         if (grant_me) begin
            owner_q <= OWN_ME;
            we_q    <= me_we_i;
            last_q  <= size_to_last(me_size_i);
            addr_q  <= me_addr_i[ADDR_W-1:0];
            cnt_q   <= 2'd0;
         end else if (grant_if) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            last_q  <= LAST_WORD;
            addr_q  <= if_addr_i[ADDR_W-1:0];
            cnt_q   <= 2'd0;
         end else if (state_q == ST_ISSUE && cnt_q != last_q) begin
            cnt_q  <= cnt_q + 2'd1;
            addr_q <= addr_q + ADDR_W'(1);
         end
         if (if_done_o)             if_data_q  <= asm_word;
         if (me_done_o && !we_q)    me_rdata_q <= asm_word;
      end
   end

   mem_byte_asm u_asm (
      .clk      (clk),
      .rst      (rst),
      .clr      (grant_if | (grant_me & ~me_we_i)),
      .ld_word  (grant_me & me_we_i),
      .word_in  (me_wdata_i),
      .ld_lane  (cap_en_q),
      .lane     (cap_lane_q),
      .byte_in  (ram_din_i),
      .sel      (cnt_q),
      .word_out (asm_word),
      .byte_out (asm_byte)
   );

   assign if_done_o  = (state_q == ST_DONE) && (owner_q == OWN_IF) && !if_cancel_i;
   assign me_done_o  = (state_q == ST_DONE) && (owner_q == OWN_ME);
   assign if_data_o  = if_done_o ? asm_word : if_data_q;
   assign me_rdata_o = (me_done_o && !we_q) ? asm_word : me_rdata_q;

   // Stall requests are forced low while reset is asserted.
   assign if_stall_req_o = rst & if_req_i & ~if_done_o;
   assign me_stall_req_o = rst & me_req_i & ~me_done_o;

   assign ram_addr_o  = addr_q;
   assign ram_we_o    = (state_q == ST_ISSUE) && we_q;
   assign ram_dout_o  = ram_we_o ? asm_byte : 8'h00;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_cancel_i = 1'b0;
   logic [31:0] if_data_o;
   logic        if_done_o;
   logic        if_stall_req_o;
   logic        me_req_i = 1'b0;
   logic        me_we_i = 1'b0;
   logic [1:0]  me_size_i = 2'd0;
   logic [31:0] me_addr_i = '0;
   logic [31:0] me_wdata_i = '0;
   logic [31:0] me_rdata_o;
   logic        me_done_o;
   logic        me_stall_req_o;
   logic [16:0] ram_addr_o;
   logic [7:0]  ram_dout_o;
   logic        ram_we_o;
   logic [7:0]  ram_din_i = '0;
   logic [1:0]  dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:(1<<17)-1];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(17), .DATA_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_i       (if_req_i),
      .if_addr_i      (if_addr_i),
      .if_cancel_i    (if_cancel_i),
      .if_data_o      (if_data_o),
      .if_done_o      (if_done_o),
      .if_stall_req_o (if_stall_req_o),
      .me_req_i       (me_req_i),
      .me_we_i        (me_we_i),
      .me_size_i      (me_size_i),
      .me_addr_i      (me_addr_i),
      .me_wdata_i     (me_wdata_i),
      .me_rdata_o     (me_rdata_o),
      .me_done_o      (me_done_o),
      .me_stall_req_o (me_stall_req_o),
      .ram_addr_o     (ram_addr_o),
      .ram_dout_o     (ram_dout_o),
      .ram_we_o       (ram_we_o),
      .ram_din_i      (ram_din_i),
      .dbg_state_o    (dbg_state_o)
   );

   // Synchronous RAM: read data appears the cycle after the address.
   always @(posedge clk) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_dout_o;
      ram_din_i <= mem[ram_addr_o];
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_me(input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
      me_req_i   = 1'b1;
      me_we_i    = we;
      me_size_i  = size;
      me_addr_i  = addr;
      me_wdata_i = wdata;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   logic [7:0] wr_bytes [4];

   initial begin
      wr_bytes[0] = 8'hDD; wr_bytes[1] = 8'hCC; wr_bytes[2] = 8'hBB; wr_bytes[3] = 8'hAA;
      mem[17'h10] = 8'h13; mem[17'h11] = 8'h57; mem[17'h12] = 8'h9B; mem[17'h13] = 8'hDF;
      mem[17'h40] = 8'h01; mem[17'h41] = 8'h23; mem[17'h42] = 8'h45; mem[17'h43] = 8'h67;
      mem[17'h1FFFF] = 8'h5A; mem[17'h00000] = 8'hC3;

      // ---- reset state ----
      #12;
      check("rst_if_data", if_data_o, 32'h0);
      check("rst_me_rdata", me_rdata_o, 32'h0);
      check("rst_ram_addr", {15'h0, ram_addr_o}, 32'h0);
      check("rst_ram_we", {31'h0, ram_we_o}, 32'h0);
      check("rst_state", {30'h0, dbg_state_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();

      // ---- IF word read at 0x10 ----
      if_req_i = 1'b1; if_addr_i = 32'h10;
      for (int c = 0; c <= 6; c++) begin
         #1;
         check("t1_done", {31'h0, if_done_o}, (c == 6) ? 32'h1 : 32'h0);
         check("t1_stall", {31'h0, if_stall_req_o}, (c < 6) ? 32'h1 : 32'h0);
         if (c >= 1 && c <= 4) check("t1_addr", {15'h0, ram_addr_o}, 32'h10 + 32'(c - 1));
         if (c == 6) check("t1_data", if_data_o, 32'hDF9B5713);
         next_cycle();
      end
      if_req_i = 1'b0;
      #1;
      check("t1_hold", if_data_o, 32'hDF9B5713);
      check("t1_idle", {30'h0, dbg_state_o}, 32'h0);
      next_cycle();

      // ---- ME word store to 0x20 ----
      drive_me(1'b1, 2'd2, 32'h20, 32'hAABBCCDD);
      for (int c = 0; c <= 5; c++) begin
         #1;
         check("t2_we", {31'h0, ram_we_o}, (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
         if (c >= 1 && c <= 4) begin
            check("t2_addr", {15'h0, ram_addr_o}, 32'h20 + 32'(c - 1));
            check("t2_dout", {24'h0, ram_dout_o}, {24'h0, wr_bytes[c-1]});
         end
         check("t2_done", {31'h0, me_done_o}, (c == 5) ? 32'h1 : 32'h0);
         next_cycle();
      end
      me_req_i = 1'b0;
      check("t2_mem", {mem[17'h23], mem[17'h22], mem[17'h21], mem[17'h20]}, 32'hAABBCCDD);
      next_cycle();

      // ---- ME byte load at 0x22 ----
      drive_me(1'b0, 2'd0, 32'h22, 32'h0);
      for (int c = 0; c <= 3; c++) begin
         #1;
         check("t2b_done", {31'h0, me_done_o}, (c == 3) ? 32'h1 : 32'h0);
         if (c == 3) check("t2b_data", me_rdata_o, 32'h000000BB);
         next_cycle();
      end
      me_req_i = 1'b0;
      next_cycle();

      // ---- simultaneous IF and ME: ME first ----
      if_req_i = 1'b1; if_addr_i = 32'h10;
      drive_me(1'b0, 2'd2, 32'h20, 32'h0);
      for (int c = 0; c <= 13; c++) begin
         if (c == 7) me_req_i = 1'b0;
         #1;
         check("t3_me_done", {31'h0, me_done_o}, (c == 6) ? 32'h1 : 32'h0);
         check("t3_if_done", {31'h0, if_done_o}, (c == 13) ? 32'h1 : 32'h0);
         check("t3_if_stall", {31'h0, if_stall_req_o}, (c < 13) ? 32'h1 : 32'h0);
         if (c < 6) check("t3_me_stall", {31'h0, me_stall_req_o}, 32'h1);
         if (c == 6) check("t3_me_data", me_rdata_o, 32'hAABBCCDD);
         if (c == 8) check("t3_if_addr", {15'h0, ram_addr_o}, 32'h10);
         if (c == 13) check("t3_if_data", if_data_o, 32'hDF9B5713);
         next_cycle();
      end
      if_req_i = 1'b0;
      next_cycle();

      // ---- IF cancel in second ISSUE cycle, then IF read at 0x40 ----
      if_req_i = 1'b1; if_addr_i = 32'h30;
      for (int c = 0; c <= 9; c++) begin
         if (c == 2) if_cancel_i = 1'b1;
         if (c == 3) begin if_cancel_i = 1'b0; if_addr_i = 32'h40; end
         #1;
         check("t4_done", {31'h0, if_done_o}, (c == 9) ? 32'h1 : 32'h0);
         if (c == 3) begin
            check("t4_idle", {30'h0, dbg_state_o}, 32'h0);
            check("t4_hold", if_data_o, 32'hDF9B5713);
         end
         if (c == 9) check("t4_data", if_data_o, 32'h67452301);
         next_cycle();
      end
      if_req_i = 1'b0;
      next_cycle();

      // ---- ME half load wrapping at 2^17-1 ----
      drive_me(1'b0, 2'd1, 32'h0001FFFF, 32'h0);
      for (int c = 0; c <= 4; c++) begin
         #1;
         if (c == 1) check("t5_addr0", {15'h0, ram_addr_o}, 32'h1FFFF);
         if (c == 2) check("t5_addr1", {15'h0, ram_addr_o}, 32'h00000);
         check("t5_done", {31'h0, me_done_o}, (c == 4) ? 32'h1 : 32'h0);
         if (c == 4) check("t5_data", me_rdata_o, 32'h0000C35A);
         next_cycle();
      end
      me_req_i = 1'b0;
      next_cycle();

      // ---- reset mid-write ----
      drive_me(1'b1, 2'd2, 32'h50, 32'h11223344);
      next_cycle();
      next_cycle();
      #1;
      check("t6_we_pre", {31'h0, ram_we_o}, 32'h1);
      rst = 1'b0;
      #1;
      check("t6_we", {31'h0, ram_we_o}, 32'h0);
      check("t6_addr", {15'h0, ram_addr_o}, 32'h0);
      check("t6_dout", {24'h0, ram_dout_o}, 32'h0);
      check("t6_outs", {28'h0, if_done_o, me_done_o, if_stall_req_o, me_stall_req_o}, 32'h0);
      check("t6_data", if_data_o | me_rdata_o, 32'h0);
      check("t6_state", {30'h0, dbg_state_o}, 32'h0);
      me_req_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      next_cycle();
      drive_me(1'b0, 2'd2, 32'h10, 32'h0);
      for (int c = 0; c <= 6; c++) begin
         #1;
         check("t6_rd_done", {31'h0, me_done_o}, (c == 6) ? 32'h1 : 32'h0);
         if (c == 6) check("t6_rd_data", me_rdata_o, 32'hDF9B5713);
         next_cycle();
      end
      me_req_i = 1'b0;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
